seg_scan_ctrl: RTL
==================

# seg_scan_ctrl

Time-multiplexed scan controller for a multi-digit common-segment 7-segment display. It holds a packed hex value of `DIGITS` nibbles and shares one hex-to-segment decode path across all digits. It drives one digit at a time with a blanking gap between digits to suppress ghosting. It sits between the lock logic, which loads code and status values, and the display pins.

## Interface
- `DIGITS`, default 4: number of digits, legal range 1..8.
- `DWELL_CYC`, default 50000: clock cycles each digit is lit, must be ≥1.
- `BLANK_CYC`, default 500: clock cycles all digits are dark before each digit slot. A value of 0 skips the BLANK state.
- `I_CLK  in  1`: single clock.
- `I_RST  in  1`: reset, synchronous, active-high.
- `I_LOAD  in  1`: load strobe. Accepted only on a cycle where `O_READY`=1.
- `I_VALUE  in  4*DIGITS`: packed value. Nibble k drives digit k; digit 0 is rightmost.
- `I_DIGIT_EN  in  DIGITS`: per-digit enable. 0 forces that digit dark while keeping its slot timing.
- `O_READY  out  1`: shadow register free.
- `O_SEG  out  7`: segments, active-high. Bit 0=a, 1=b, 2=c, 3=d, 4=e, 5=f, 6=g.
- `O_ANODE  out  DIGITS`: digit select, one-hot or zero, active-high.
- `O_FRAME  out  1`: one-cycle pulse at each frame wrap.

## Operation
- Registers:
  - active value
  - shadow value
  - pending flag
  - digit index `idx`
  - slot counter `cnt`
  - state, one of {BLANK, SHOW}
- Reset state: `O_SEG`=0, `O_ANODE`=0, `O_READY`=1, `O_FRAME`=0, active=0, pending=0, `idx`=0, `cnt`=0, state=BLANK.
- BLANK: `O_ANODE`=0 and `O_SEG`=0. After `BLANK_CYC` cycles → SHOW.
- SHOW:
  - `O_ANODE[idx]`=1 if the digit is visible, else all 0.
  - `O_SEG` = glyph of active nibble `idx` if visible, else 0.
  - After `DWELL_CYC` cycles → BLANK, with `idx` = `idx`+1.
  - If `idx`=`DIGITS`-1, `idx` wraps to 0 instead. This is the frame wrap.
- Visibility: `I_DIGIT_EN[idx]`, sampled on the BLANK→SHOW edge and held for the slot.
- Glyphs, standard hex: 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07, 8 7F, 9 6F, A 77, b 7C, C 39, d 5E, E 79, F 71.
- Load handshake:
  - `I_LOAD`=1 with `O_READY`=1 copies `I_VALUE` to shadow and sets pending.
  - `O_READY`=0 from the next cycle.
  - `I_LOAD` with `O_READY`=0 is ignored.
- Commit at frame wrap when pending:
  - active ← shadow and pending cleared.
  - `O_READY`=1 on the first cycle of the new frame.
  - A load accepted on the wrap edge itself is not committed on that wrap. It commits at the next wrap.
- Displayed value never tears: a frame always shows a single active value.
- Reset mid-operation: on the next edge all registers return to reset state and any pending value is discarded.

## Timing
- All outputs are registered. `O_SEG` and `O_ANODE` change on the same edge.
- Frame length = `DIGITS`*(`BLANK_CYC`+`DWELL_CYC`) cycles.
- After reset release: BLANK for `BLANK_CYC` cycles, then digit 0 SHOW.
- `O_FRAME`: high for exactly the first cycle after each wrap edge. It is not asserted on reset exit.
- Load-to-display latency: from the accepting edge to the next wrap, at most one frame plus one cycle.
- `cnt` width = `$clog2`(max(`DWELL_CYC`,`BLANK_CYC`)+1). `cnt` resets to 0 on every state change.

## Configuration
- `SEG_SCAN_LZ_BLANK_EN` defined: leading-zero suppression.
  - Any digit k>0 is dark when nibble k and all higher nibbles are 0.
  - Digit 0 always follows `I_DIGIT_EN` only.
  - Suppression is ANDed with `I_DIGIT_EN` and evaluated on the active value.
- Not defined: all enabled digits are shown, including zeros. No suppression logic is generated.

## Structure
- Package `seg_scan_pkg` holds:
  - state enum {BLANK, SHOW}
  - glyph constants `SEG_BLANK`=7'h00 and `SEG_ZERO`=7'h3F
  - segment bit-index localparams.
- Sub-module `hex_seg_lut`: combinational 4-bit→7-bit glyph table, instantiated once on the selected nibble.

## Test plan
- Reset: hold `I_RST` 2 cycles (`DIGITS`=4, `DWELL_CYC`=4, `BLANK_CYC`=2) → `O_SEG`=0, `O_ANODE`=0, `O_READY`=1. Then 2 dark cycles, then `O_ANODE`=4'b0001 and `O_SEG`=7'h3F for 4 cycles.
- Load 16'h1234 → `O_READY`=0 until wrap, `O_FRAME` pulses, `O_READY`=1. The next frame shows each digit for 4 cycles with 2 dark cycles between: digit 0 7'h66, digit 1 7'h4F, digit 2 7'h5B, digit 3 7'h06.
- Second `I_LOAD` of 16'hFFFF while `O_READY`=0 → ignored. The following frame still shows 1234.
- `I_DIGIT_EN`=4'b1010 → `O_ANODE` stays 0 during slots 0 and 2. Slots 1 and 3 are lit, and frame length is unchanged at 24 cycles.
- With `SEG_SCAN_LZ_BLANK_EN`:
  - value 16'h0070 → digits 3 and 2 dark, digit 1 7'h07, digit 0 7'h3F.
  - value 16'h0000 → only digit 0 lit, at 7'h3F.
- Assert `I_RST` during the SHOW slot of digit 2 → next cycle all outputs at reset values and active=0. Scan restarts from digit 0 after `BLANK_CYC`.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg_scan_pkg;

    // Scan phase: all digits dark, or one digit slot lit
    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_ZERO  = 7'h3F;

    // Segment bit positions within the 7-bit glyph
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

endpackage

// File: rtl/hex_seg_lut.sv
// Combinational hex nibble to 7-segment glyph table (active-high, bit 0 = a).
module hex_seg_lut
    import seg_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Standard hex glyphs, lowercase b and d to keep them distinct from 8 and 0
    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_ZERO;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-segment 7-segment display.
// A double-buffered value (shadow -> active) is committed only at frame wrap
// so a frame never shows a mix of two values.
// Optional build macro: SEG_SCAN_LZ_BLANK_EN enables leading-zero suppression.
//
// state | meaning
// BLANK | all anodes off for BLANK_CYC cycles before the next digit slot
// SHOW  | digit idx driven (if visible) for DWELL_CYC cycles
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int DWELL_CYC = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic                  I_CLK,
    input  logic                  I_RST,
    input  logic                  I_LOAD,
    input  logic [4*DIGITS-1:0]   I_VALUE,
    input  logic [DIGITS-1:0]     I_DIGIT_EN,
    output logic                  O_READY,
    output logic [6:0]            O_SEG,
    output logic [DIGITS-1:0]     O_ANODE,
    output logic                  O_FRAME
);

    localparam int MAX_CYC    = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
    localparam int CW         = $clog2(MAX_CYC + 1);
    localparam int IW         = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BLANK_LAST = (BLANK_CYC > 0) ? BLANK_CYC - 1 : 0;
    localparam logic [CW-1:0] CNT_BLANK_END = CW'(BLANK_LAST);
    localparam logic [CW-1:0] CNT_SHOW_END  = CW'(DWELL_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST      = IW'(DIGITS - 1);
    localparam bit            SKIP_BLANK    = (BLANK_CYC == 0);

    scan_state_t           state;
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   active;
    logic [4*DIGITS-1:0]   shadow;
    logic                  pending;

    logic                  blank_end;
    logic                  show_end;
    logic                  wrap;
    logic                  commit;
    logic                  accept;
    logic                  pending_nxt;
    logic                  enter_show;
    logic [IW-1:0]         idx_nxt;
    logic [4*DIGITS-1:0]   active_nxt;
    logic [3:0]            sel_nibble;
    logic [6:0]            glyph;
    logic                  lz_ok;
    logic                  visible;

    // Slot timing and the value the next slot will be drawn from; glyph and
    // visibility use post-commit values so a zero-blank wrap shows the new value
    always_comb begin
        blank_end   = (state == BLANK) && (cnt == CNT_BLANK_END);
        show_end    = (state == SHOW) && (cnt == CNT_SHOW_END);
        wrap        = show_end && (idx == IDX_LAST);
        commit      = wrap && pending;
        accept      = I_LOAD && O_READY;
        pending_nxt = accept | (pending & ~commit);
        enter_show  = blank_end || (show_end && SKIP_BLANK);
        idx_nxt     = idx;
        if (show_end) idx_nxt = wrap ? '0 : idx + 1'b1;
        active_nxt  = commit ? shadow : active;
        sel_nibble  = active_nxt[4*idx_nxt +: 4];
    end

`ifdef SEG_SCAN_LZ_BLANK_EN
    // Digit k>0 goes dark when it and every higher nibble are zero
    always_comb begin
        lz_ok = (idx_nxt == '0) || ((active_nxt >> (4*idx_nxt)) != '0);
    end
`else
    assign lz_ok = 1'b1;
`endif

    assign visible = I_DIGIT_EN[idx_nxt] & lz_ok;

    hex_seg_lut u_lut (
        .nibble (sel_nibble),
        .seg    (glyph)
    );

    // Scan FSM, load handshake and registered display outputs
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state   <= BLANK;
            cnt     <= '0;
            idx     <= '0;
            active  <= '0;
            shadow  <= '0;
            pending <= 1'b0;
            O_READY <= 1'b1;
            O_SEG   <= SEG_BLANK;
            O_ANODE <= '0;
            O_FRAME <= 1'b0;
        end else begin
            if (accept) shadow <= I_VALUE;
            pending <= pending_nxt;
            O_READY <= ~pending_nxt;
            active  <= active_nxt;
            idx     <= idx_nxt;
            O_FRAME <= wrap;

            if (blank_end) begin
                state <= SHOW;
                cnt   <= '0;
            end else if (show_end) begin
                state <= SKIP_BLANK ? SHOW : BLANK;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (enter_show) begin
                O_ANODE <= visible ? (DIGITS'(1) << idx_nxt) : '0;
                O_SEG   <= visible ? glyph : SEG_BLANK;
            end else if (show_end) begin
                O_ANODE <= '0;
                O_SEG   <= SEG_BLANK;
            end
        end
    end

endmodule
